simon_sequence: RTL and testbench
=================================

# simon_sequence

Sequence store and playback/check engine for the Simon Says game. It sits directly downstream of the `rng` block: each round it captures `rng.number_out` as the next colour and appends it to an on-chip sequence. It plays the whole sequence back on the four colour LEDs with programmable on/off timing, then checks the player's presses against the stored colours one by one. The game FSM drives it with single-cycle command pulses and reacts to its match/mismatch/round-done pulses.

## Interface
Parameters:
- `MAX_LEN`, 32: maximum sequence length (≥2)
- `SHOW_TICKS`, 50: cycles each colour is lit during playback (≥1)
- `GAP_TICKS`, 10: dark cycles after each lit colour (≥1)

Ports (LW = $clog2(MAX_LEN+1)):
- `clk`  in  1  system clock. One clock; all logic is clocked on its rising edge.
- `reset`  in  1  reset, asynchronous and active-low; clears all state immediately.
- `rnd_i`  in  2  colour from `rng.number_out` (0..3)
- `clear_i`  in  1  start a new game; sequence length goes to 0
- `append_i`  in  1  pulse; store `rnd_i` as the next sequence element
- `play_i`  in  1  pulse; start playback of the stored sequence
- `guess_valid_i`  in  1  one-cycle strobe that qualifies `guess_i`
- `guess_i`  in  2  colour pressed by the player
- `led_o`  out  4  one-hot lit colour (bit n = colour n); 0 when dark
- `busy_o`  out  1  high whenever state ≠ IDLE
- `len_o`  out  LW  current sequence length
- `full_o`  out  1  `len_o` == MAX_LEN
- `match_o`  out  1  one-cycle pulse: guess correct
- `mismatch_o`  out  1  one-cycle pulse: guess wrong
- `round_done_o`  out  1  one-cycle pulse: last element matched

## Operation
- Storage: MAX_LEN×2-bit register array `mem`, an index counter `idx`, a tick counter, and `len`. All are reset to 0.
- States: IDLE, SHOW, GAP, CHECK.
- `clear_i` has top priority in every state. Next cycle: `len`=0, `idx`=0, state=IDLE, `led_o`=0, no pulses. `mem` contents are left unchanged.
- IDLE command priority is clear > append > play. Only the highest-priority asserted command acts.
  - Append: `mem[len]`←`rnd_i`, `len`++. Ignored when `full_o`=1.
  - Play: if `len`=0, ignored. Otherwise go to SHOW with `idx`=0 and the tick counter at 0.
- SHOW: `led_o` = one-hot(`mem[idx]`) for exactly SHOW_TICKS cycles, then go to GAP.
- GAP: `led_o`=0 for exactly GAP_TICKS cycles. Then:
  - if `idx`=`len`-1: go to CHECK with `idx`=0;
  - otherwise: `idx`++ and return to SHOW.
- CHECK: on `guess_valid_i`, compare `guess_i` with `mem[idx]`.
  - Equal: pulse `match_o`. If `idx`=`len`-1, also pulse `round_done_o` and go to IDLE. Otherwise `idx`++.
  - Unequal: pulse `mismatch_o` and go to IDLE. `len` is unchanged.
- Ignored inputs:
  - `append_i` and `play_i` outside IDLE.
  - `guess_valid_i` outside CHECK.
  - Any `rnd_i` value when not appending.
- Never both `match_o` and `mismatch_o` in one cycle.

## Timing
- All outputs are registered.
- Reset values: `led_o`=0, `busy_o`=0, `len_o`=0, `full_o`=0, `match_o`=0, `mismatch_o`=0, `round_done_o`=0.
- Append: `rnd_i` is sampled at the same edge as `append_i`. `len_o`/`full_o` update 1 cycle later.
- Play: `play_i` is sampled at edge T. From T+1, `busy_o`=1 and `led_o` shows colour 0.
- Total playback is `len`×(SHOW_TICKS+GAP_TICKS) cycles; CHECK is entered on the following cycle.
- Guess: a strobe at edge T produces `match_o`/`mismatch_o` high for cycle T+1 only. `round_done_o` coincides with the final `match_o`. `busy_o` falls in cycle T+1 of that final or failing guess.
- Back-to-back guesses on consecutive cycles are all accepted.
- Clear during SHOW/GAP/CHECK: `led_o` and `busy_o` go to 0 on the next cycle. A guess strobe in the same cycle as the clear produces no pulse.
- Asynchronous reset mid-operation: all outputs go to reset values immediately, without waiting for a clock edge. Operation resumes from IDLE after the first edge with `reset` high.
- `idx` and tick counters never wrap; their bounds are set by `len` and the parameters.

## Test plan
- Setup for all tests: SHOW_TICKS=4, GAP_TICKS=2.
- Append with `rnd_i`=2,0,3 -> `len_o`=3. Then `play_i` -> `led_o` sequence:
  - 0100 ×4, 0 ×2
  - 0001 ×4, 0 ×2
  - 1000 ×4, 0 ×2
  - then `busy_o` stays 1 in CHECK.
- In CHECK, guesses 2,0,3 on consecutive cycles -> three `match_o` pulses, `round_done_o` with the third, `busy_o`=0 the same cycle.
- Replay, then guesses 2,1 -> one `match_o`, then `mismatch_o`, IDLE, `len_o` still 3, no `round_done_o`.
- MAX_LEN=4, five appends (1,2,3,0,2) -> `len_o`=4, `full_o`=1, fifth append ignored. Playback shows 0010, 0100, 1000, 0001.
- `clear_i` mid-SHOW -> next cycle `led_o`=0, `busy_o`=0, `len_o`=0. A subsequent `play_i` is ignored (`busy_o` stays 0).
- `append_i`+`play_i` together in IDLE -> only the append acts. Async `reset` low mid-CHECK -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/simon_sequence.sv
// Simon Says sequence store: appends colours from the rng, plays them back on
// one-hot LEDs with SHOW/GAP timing, then checks player guesses in order.
module simon_sequence #(
  parameter  int MAX_LEN    = 32,
  parameter  int SHOW_TICKS = 50,
  parameter  int GAP_TICKS  = 10,
  localparam int LW         = $clog2(MAX_LEN+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    rnd_i,
  input  logic          clear_i,
  input  logic          append_i,
  input  logic          play_i,
  input  logic          guess_valid_i,
  input  logic [1:0]    guess_i,
  output logic [3:0]    led_o,
  output logic          busy_o,
  output logic [LW-1:0] len_o,
  output logic          full_o,
  output logic          match_o,
  output logic          mismatch_o,
  output logic          round_done_o
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TW    = $clog2(TMAX+1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_CHECK} state_t;

  state_t        r_state;
  logic [1:0]    r_mem [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [TW-1:0] r_tick;
  logic [3:0]    r_led;
  logic          r_match;
  logic          r_mismatch;
  logic          r_done;

  logic [LW-1:0] w_idx_nxt;
  logic [LW-1:0] w_last;
  logic          w_full;
  logic [1:0]    w_cur;
  logic [1:0]    w_nxt;
  logic [AW-1:0] w_wr;

  assign w_idx_nxt = r_idx + LW'(1);
  assign w_last    = r_len - LW'(1);
  assign w_full    = (r_len == LW'(MAX_LEN));
  assign w_wr      = r_len[AW-1:0];
  assign w_cur     = r_mem[r_idx[AW-1:0]];
  assign w_nxt     = r_mem[w_idx_nxt[AW-1:0]];

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_tick     <= '0;
      r_led      <= '0;
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) r_mem[i] <= 2'd0;
    end else begin
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
      r_done     <= 1'b0;
      if (clear_i) begin
        // mem is deliberately kept; len=0 makes it unreachable anyway
        r_state <= S_IDLE;
        r_len   <= '0;
        r_idx   <= '0;
        r_tick  <= '0;
        r_led   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (append_i) begin
              if (!w_full) begin
                r_mem[w_wr] <= rnd_i;
                r_len       <= r_len + LW'(1);
              end
            end else if (play_i && (r_len != '0)) begin
              r_state <= S_SHOW;
              r_idx   <= '0;
              r_tick  <= '0;
              r_led   <= onehot(r_mem[0]);
            end
          end
          S_SHOW: begin
            if (r_tick == TW'(SHOW_TICKS-1)) begin
              r_state <= S_GAP;
              r_tick  <= '0;
              r_led   <= '0;
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          S_GAP: begin
            if (r_tick == TW'(GAP_TICKS-1)) begin
              r_tick <= '0;
              if (r_idx == w_last) begin
                r_state <= S_CHECK;
                r_idx   <= '0;
              end else begin
                // LED for the next element is loaded here so SHOW starts lit
                r_state <= S_SHOW;
                r_idx   <= w_idx_nxt;
                r_led   <= onehot(w_nxt);
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          S_CHECK: begin
            if (guess_valid_i) begin
              if (guess_i == w_cur) begin
                r_match <= 1'b1;
                if (r_idx == w_last) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
                  r_idx   <= '0;
                end else begin
                  r_idx <= w_idx_nxt;
                end
              end else begin
                r_mismatch <= 1'b1;
                r_state    <= S_IDLE;
                r_idx      <= '0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign led_o        = r_led;
  assign busy_o       = (r_state != S_IDLE);
  assign len_o        = r_len;
  assign full_o       = w_full;
  assign match_o      = r_match;
  assign mismatch_o   = r_mismatch;
  assign round_done_o = r_done;

endmodule

// File: tb/tb_simon_sequence.sv
// Directed bench for simon_sequence with MAX_LEN=4, SHOW_TICKS=4, GAP_TICKS=2.
module tb_simon_sequence;

  localparam int MAX_LEN = 4;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam int LW      = $clog2(MAX_LEN+1);

  logic          clk;
  logic          reset;
  logic [1:0]    rnd_i;
  logic          clear_i;
  logic          append_i;
  logic          play_i;
  logic          guess_valid_i;
  logic [1:0]    guess_i;
  logic [3:0]    led_o;
  logic          busy_o;
  logic [LW-1:0] len_o;
  logic          full_o;
  logic          match_o;
  logic          mismatch_o;
  logic          round_done_o;

  int checks = 0;
  int errors = 0;

  simon_sequence #(.MAX_LEN(MAX_LEN), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP)) dut (
    .clk(clk), .reset(reset), .rnd_i(rnd_i), .clear_i(clear_i),
    .append_i(append_i), .play_i(play_i), .guess_valid_i(guess_valid_i),
    .guess_i(guess_i), .led_o(led_o), .busy_o(busy_o), .len_o(len_o),
    .full_o(full_o), .match_o(match_o), .mismatch_o(mismatch_o),
    .round_done_o(round_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_append(input logic [1:0] c);
    append_i = 1'b1;
    rnd_i    = c;
    step();
    append_i = 1'b0;
    rnd_i    = 2'd0;
  endtask

  // Play and check every cycle of the LED pattern, then confirm CHECK entry.
  task automatic play_seq(input int n, input logic [3:0][3:0] leds);
    logic [3:0] exp;
    play_i = 1'b1;
    step();
    play_i = 1'b0;
    for (int k = 0; k < n*(SHOW+GAP); k++) begin
      exp = ((k % (SHOW+GAP)) < SHOW) ? leds[k/(SHOW+GAP)] : 4'b0000;
      checks++;
      if (led_o !== exp || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL playback cyc %0d: led=%b busy=%b, expected led=%b busy=1", k, led_o, busy_o, exp);
      end
      step();
    end
    checks++;
    if (led_o !== 4'b0000 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL check_entry: led=%b busy=%b, expected led=0000 busy=1", led_o, busy_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({led_o, busy_o, len_o, full_o, match_o, mismatch_o, round_done_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: led=%b busy=%b len=%0d full=%b m=%b mm=%b rd=%b, expected all 0",
               led_o, busy_o, len_o, full_o, match_o, mismatch_o, round_done_o);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_append();
    do_append(2'd2);
    checks++;
    if (len_o !== 3'd1) begin errors++; $display("FAIL append1_len: got %0d expected 1", len_o); end
    do_append(2'd0);
    do_append(2'd3);
    checks++;
    if (len_o !== 3'd3 || full_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL append3: len=%0d full=%b busy=%b, expected 3 0 0", len_o, full_o, busy_o);
    end
  endtask

  task automatic test_round_ok();
    play_seq(3, {4'b0000, 4'b1000, 4'b0001, 4'b0100});
    guess_valid_i = 1'b1;
    guess_i = 2'd2;
    step();
    checks++;
    if (match_o !== 1'b1 || mismatch_o !== 1'b0 || round_done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL guess1: m=%b mm=%b rd=%b busy=%b, expected 1 0 0 1", match_o, mismatch_o, round_done_o, busy_o);
    end
    guess_i = 2'd0;
    step();
    checks++;
    if (match_o !== 1'b1 || round_done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL guess2: m=%b rd=%b busy=%b, expected 1 0 1", match_o, round_done_o, busy_o);
    end
    guess_i = 2'd3;
    step();
    guess_valid_i = 1'b0;
    checks++;
    if (match_o !== 1'b1 || round_done_o !== 1'b1 || busy_o !== 1'b0 || mismatch_o !== 1'b0) begin
      errors++;
      $display("FAIL guess3_done: m=%b rd=%b busy=%b mm=%b, expected 1 1 0 0", match_o, round_done_o, busy_o, mismatch_o);
    end
    step();
    checks++;
    if (match_o !== 1'b0 || round_done_o !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: m=%b rd=%b, expected 0 0", match_o, round_done_o);
    end
  endtask

  task automatic test_mismatch();
    play_seq(3, {4'b0000, 4'b1000, 4'b0001, 4'b0100});
    guess_valid_i = 1'b1;
    guess_i = 2'd2;
    step();
    checks++;
    if (match_o !== 1'b1 || mismatch_o !== 1'b0) begin
      errors++;
      $display("FAIL mm_guess1: m=%b mm=%b, expected 1 0", match_o, mismatch_o);
    end
    guess_i = 2'd1;
    step();
    guess_valid_i = 1'b0;
    checks++;
    if (match_o !== 1'b0 || mismatch_o !== 1'b1 || round_done_o !== 1'b0 || busy_o !== 1'b0 || len_o !== 3'd3) begin
      errors++;
      $display("FAIL mm_guess2: m=%b mm=%b rd=%b busy=%b len=%0d, expected 0 1 0 0 3",
               match_o, mismatch_o, round_done_o, busy_o, len_o);
    end
  endtask

  task automatic test_idle_guess();
    guess_valid_i = 1'b1;
    guess_i = 2'd2;
    step();
    guess_valid_i = 1'b0;
    checks++;
    if (match_o !== 1'b0 || mismatch_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_guess: m=%b mm=%b busy=%b, expected 0 0 0", match_o, mismatch_o, busy_o);
    end
  endtask

  task automatic test_full();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (len_o !== 3'd0) begin errors++; $display("FAIL clear_len: got %0d expected 0", len_o); end
    do_append(2'd1);
    do_append(2'd2);
    do_append(2'd3);
    checks++;
    if (full_o !== 1'b0) begin errors++; $display("FAIL not_full: full=%b expected 0", full_o); end
    do_append(2'd0);
    checks++;
    if (len_o !== 3'd4 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL full4: len=%0d full=%b, expected 4 1", len_o, full_o);
    end
    do_append(2'd2);
    checks++;
    if (len_o !== 3'd4 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL fifth_append: len=%0d full=%b, expected 4 1", len_o, full_o);
    end
    play_seq(4, {4'b0001, 4'b1000, 4'b0100, 4'b0010});
  endtask

  task automatic test_async_reset();
    guess_valid_i = 1'b1;
    guess_i = 2'd1;
    step();
    guess_valid_i = 1'b0;
    checks++;
    if (match_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_match: m=%b busy=%b, expected 1 1", match_o, busy_o);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({led_o, busy_o, len_o, full_o, match_o, mismatch_o, round_done_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: led=%b busy=%b len=%0d full=%b m=%b mm=%b rd=%b, expected all 0",
               led_o, busy_o, len_o, full_o, match_o, mismatch_o, round_done_o);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_clear_show();
    do_append(2'd2);
    do_append(2'd0);
    play_i = 1'b1;
    step();
    play_i = 1'b0;
    step();
    checks++;
    if (led_o !== 4'b0100 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_show: led=%b busy=%b, expected 0100 1", led_o, busy_o);
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (led_o !== 4'b0000 || busy_o !== 1'b0 || len_o !== 3'd0) begin
      errors++;
      $display("FAIL clear_show: led=%b busy=%b len=%0d, expected 0000 0 0", led_o, busy_o, len_o);
    end
    play_i = 1'b1;
    step();
    play_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || led_o !== 4'b0000) begin
      errors++;
      $display("FAIL play_empty: busy=%b led=%b, expected 0 0000", busy_o, led_o);
    end
  endtask

  task automatic test_clear_check();
    do_append(2'd3);
    play_seq(1, {4'b0000, 4'b0000, 4'b0000, 4'b1000});
    clear_i = 1'b1;
    guess_valid_i = 1'b1;
    guess_i = 2'd3;
    step();
    clear_i = 1'b0;
    guess_valid_i = 1'b0;
    checks++;
    if (match_o !== 1'b0 || mismatch_o !== 1'b0 || round_done_o !== 1'b0 || busy_o !== 1'b0 || len_o !== 3'd0) begin
      errors++;
      $display("FAIL clear_check: m=%b mm=%b rd=%b busy=%b len=%0d, expected 0 0 0 0 0",
               match_o, mismatch_o, round_done_o, busy_o, len_o);
    end
  endtask

  task automatic test_append_play();
    append_i = 1'b1;
    play_i   = 1'b1;
    rnd_i    = 2'd1;
    step();
    append_i = 1'b0;
    play_i   = 1'b0;
    checks++;
    if (len_o !== 3'd1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL append_play: len=%0d busy=%b, expected 1 0", len_o, busy_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || led_o !== 4'b0000) begin
      errors++;
      $display("FAIL append_play_idle: busy=%b led=%b, expected 0 0000", busy_o, led_o);
    end
  endtask

  initial begin
    rnd_i = 2'd0; clear_i = 1'b0; append_i = 1'b0; play_i = 1'b0;
    guess_valid_i = 1'b0; guess_i = 2'd0;
    test_reset();
    test_append();
    test_round_ok();
    test_mismatch();
    test_idle_guess();
    test_full();
    test_async_reset();
    test_clear_show();
    test_clear_check();
    test_append_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
